// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for regfile_mp_sb: read ports, write ports, scoreboard set and pending count.
// The issue/writeback side drives the master modport. The register file uses the slave modport.
interface regfile_mp_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                sb_set_en;
    logic [AW-1:0]       sb_set_addr;
    logic [AW:0]         pend_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
        input  rd_data, rd_busy, pend_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
        output rd_data, rd_busy, pend_cnt
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with an optional hardwired zero register and write-to-read bypass.
// It also keeps a per-register pending scoreboard with an incrementally maintained pending count.
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic            clk,
    input logic            rst,
    regfile_mp_sb_if.slave bus
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef logic [AW-1:0]   addr_t;
    typedef logic [XLEN-1:0] word_t;

    word_t            regs   [NREGS];
    word_t            wr_val [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pend_nxt;
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] set_hit;
    logic [AW:0]      pend_cnt_q;
    logic [AW:0]      n_set;
    logic [AW:0]      n_clr;
    logic [AW:0]      pop_cnt;

    // Per-register write resolution: ascending port scan lets the highest-index port win.
    // Addresses at or above NREGS never match any i, so such writes fall away without aliasing.
    // NOTE: every variable gets a default at the top of the block so that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            wr_hit[i]  = 1'b0;
            wr_val[i]  = '0;
            set_hit[i] = 1'b0;
            for (int w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == AW'(i)) begin
                    wr_hit[i] = 1'b1;
                    wr_val[i] = bus.wr_data[w*XLEN +: XLEN];
                end
            end
            if (bus.sb_set_en && bus.sb_set_addr == AW'(i)) begin
                set_hit[i] = 1'b1;
            end
            if (ZERO_REG != 0 && i == 0) begin
                wr_hit[i]  = 1'b0;
                set_hit[i] = 1'b0;
            end
        end
    end

    // A set wins over a clear in the same cycle, because a new producer has just been issued.
    assign pend_nxt = set_hit | (pending & ~wr_hit);

    always_comb begin
        n_set   = '0;
        n_clr   = '0;
        pop_cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (pend_nxt[i] && !pending[i]) n_set = n_set + (AW+1)'(1);
            if (!pend_nxt[i] && pending[i]) n_clr = n_clr + (AW+1)'(1);
            if (pending[i])                 pop_cnt = pop_cnt + (AW+1)'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    // NOTE: the array is built from flops rather than SRAM, so it can be cleared asynchronously along with the scoreboard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pending    <= '0;
            pend_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_hit[i]) regs[i] <= wr_val[i];
            end
            pending    <= pend_nxt;
            pend_cnt_q <= pend_cnt_q + n_set - n_clr;
        end
    end

    assign bus.pend_cnt = pend_cnt_q;

    // Combinational read. The zero register and out-of-range addresses leave 'valid' low and read 0.
    always_comb begin
        addr_t a;
        word_t d;
        logic  b;
        logic  valid;
        logic  byp_hit;
        a             = '0;
        d             = '0;
        b             = 1'b0;
        valid         = 1'b0;
        byp_hit       = 1'b0;
        bus.rd_data   = '0;
        bus.rd_busy   = '0;
        for (int p = 0; p < NRD; p++) begin
            a       = bus.rd_addr[p*AW +: AW];
            d       = '0;
            b       = 1'b0;
            valid   = 1'b0;
            byp_hit = 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                if (a == AW'(i) && !(ZERO_REG != 0 && i == 0)) begin
                    valid = 1'b1;
                    d     = regs[i];
                    b     = pending[i];
                end
            end
            if (BYPASS != 0 && valid) begin
                for (int w = 0; w < NWR; w++) begin
                    if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == a) begin
                        d       = bus.wr_data[w*XLEN +: XLEN];
                        byp_hit = 1'b1;
                    end
                end
                if (byp_hit && !(bus.sb_set_en && bus.sb_set_addr == a)) b = 1'b0;
            end
            if (!rst) begin
                d = '0;
                b = 1'b0;
            end
            bus.rd_data[p*XLEN +: XLEN] = d;
            bus.rd_busy[p]              = b;
        end
    end

    a_cnt_is_popcount: assert property (@(posedge clk) disable iff (!rst)
        pend_cnt_q == pop_cnt);

    a_zero_reg_clean: assert property (@(posedge clk) disable iff (!rst)
        (ZERO_REG == 0) || (!pending[0] && regs[0] == '0));
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed and random bench for regfile_mp_sb. It drives a bypass and a non-bypass instance in lockstep.
// Both instances are checked against a rule-level reference model.
module tb_regfile_mp_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int NRD   = 3;
    localparam int NWR   = 2;
    localparam int AW    = 4;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                sb_set_en;
    logic [AW-1:0]       sb_set_addr;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] mregs [NREGS];
    bit              mpend [NREGS];

    regfile_mp_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) if_b ();
    regfile_mp_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) if_n ();

    assign if_b.rd_addr     = rd_addr;
    assign if_b.wr_en       = wr_en;
    assign if_b.wr_addr     = wr_addr;
    assign if_b.wr_data     = wr_data;
    assign if_b.sb_set_en   = sb_set_en;
    assign if_b.sb_set_addr = sb_set_addr;
    assign if_n.rd_addr     = rd_addr;
    assign if_n.wr_en       = wr_en;
    assign if_n.wr_addr     = wr_addr;
    assign if_n.wr_data     = wr_data;
    assign if_n.sb_set_en   = sb_set_en;
    assign if_n.sb_set_addr = sb_set_addr;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1))
        u_byp (.clk(clk), .rst(rst), .bus(if_b));
    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0))
        u_nob (.clk(clk), .rst(rst), .bus(if_n));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_data(int a, bit byp);
        logic [XLEN-1:0] d;
        if (!rst || a == 0) return '0;
        d = mregs[a];
        if (byp) begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) d = wr_data[w*XLEN +: XLEN];
            end
        end
        return d;
    endfunction

    function automatic bit exp_busy(int a, bit byp);
        bit written;
        if (!rst || a == 0) return 1'b0;
        written = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) written = 1'b1;
        end
        if (byp && written && !(sb_set_en && int'(sb_set_addr) == a)) return 1'b0;
        return mpend[a];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(mpend[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            mregs[i] = '0;
            mpend[i] = 1'b0;
        end
    endtask

    // Applies the rules at a clock edge: last enabled port wins, r0 is immune, and a set beats a clear.
    task automatic model_step();
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] != '0)
                mregs[int'(wr_addr[w*AW +: AW])] = wr_data[w*XLEN +: XLEN];
        end
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) mpend[int'(wr_addr[w*AW +: AW])] = 1'b0;
        end
        if (sb_set_en && sb_set_addr != '0) mpend[int'(sb_set_addr)] = 1'b1;
    endtask

    task automatic check_outputs();
        int a;
        for (int p = 0; p < NRD; p++) begin
            a = int'(rd_addr[p*AW +: AW]);
            check($sformatf("byp_data[%0d]", p), if_b.rd_data[p*XLEN +: XLEN], exp_data(a, 1'b1));
            check($sformatf("nob_data[%0d]", p), if_n.rd_data[p*XLEN +: XLEN], exp_data(a, 1'b0));
            check($sformatf("byp_busy[%0d]", p), 32'(if_b.rd_busy[p]), 32'(exp_busy(a, 1'b1)));
            check($sformatf("nob_busy[%0d]", p), 32'(if_n.rd_busy[p]), 32'(exp_busy(a, 1'b0)));
        end
        check("byp_cnt", 32'(if_b.pend_cnt), 32'(exp_cnt()));
        check("nob_cnt", 32'(if_n.pend_cnt), 32'(exp_cnt()));
    endtask

    // Called in the low phase: checks the settled outputs, then advances the model across one edge.
    task automatic tick();
        #2 check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en     = '0;
        sb_set_en = 1'b0;
    endtask

    task automatic set_rd(int a0, int a1, int a2);
        rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic set_wr(int port, int addr, logic [XLEN-1:0] data);
        wr_en[port]                  = 1'b1;
        wr_addr[port*AW +: AW]       = AW'(addr);
        wr_data[port*XLEN +: XLEN]   = data;
    endtask

    task automatic set_sb(int addr);
        sb_set_en   = 1'b1;
        sb_set_addr = AW'(addr);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        rd_addr     = '0;
        wr_addr     = '0;
        wr_data     = '0;
        sb_set_addr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        set_rd(5, 0, 1);
        #2 check_outputs();
        check("rst_cnt", 32'(if_b.pend_cnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Reset asserted mid-cycle clears data and scoreboard, even with a write in flight.
        set_wr(0, 5, 32'hDEADBEEF);
        set_sb(5);
        tick();
        idle();
        #1 check("t1_r5_written", if_n.rd_data[31:0], 32'hDEADBEEF);
        check("t1_cnt_before", 32'(if_b.pend_cnt), 32'd1);
        #1 rst = 1'b0;
        model_reset();
        #1 check("t1_r5_after_rst", if_b.rd_data[31:0], 32'd0);
        check("t1_cnt_after_rst", 32'(if_n.pend_cnt), 32'd0);
        check("t1_busy_after_rst", 32'(if_b.rd_busy[0]), 32'd0);
        set_wr(0, 5, 32'h0000CAFE);
        #1 check("t1_byp_in_rst", if_b.rd_data[31:0], 32'd0);
        check_outputs();
        @(negedge clk);
        idle();
        #1 rst = 1'b1;
        #1 check_outputs();
        @(negedge clk);

        // Zero register: writes and scoreboard sets to r0 are ignored.
        set_rd(0, 5, 0);
        set_wr(0, 0, 32'h1234);
        set_sb(0);
        tick();
        idle();
        #1 check("t2_r0_data", if_b.rd_data[31:0], 32'd0);
        check("t2_r0_busy", 32'(if_b.rd_busy[0]), 32'd0);
        check("t2_cnt", 32'(if_b.pend_cnt), 32'd0);

        // Same-address write conflict: the higher port wins, forwarded only with bypass.
        set_wr(0, 7, 32'h77);
        tick();
        idle();
        set_rd(7, 0, 0);
        set_wr(0, 7, 32'hA);
        set_wr(1, 7, 32'hB);
        #1 check("t3_byp_same_cycle", if_b.rd_data[31:0], 32'hB);
        check("t3_nob_same_cycle", if_n.rd_data[31:0], 32'h77);
        tick();
        idle();
        #1 check("t3_byp_next", if_b.rd_data[31:0], 32'hB);
        check("t3_nob_next", if_n.rd_data[31:0], 32'hB);

        // Scoreboard set and writeback clear.
        set_sb(3);
        tick();
        idle();
        set_sb(4);
        tick();
        idle();
        set_rd(3, 4, 0);
        #1 check("t4_cnt2", 32'(if_b.pend_cnt), 32'd2);
        check("t4_busy_r3", 32'(if_n.rd_busy[0]), 32'd1);
        set_wr(0, 3, 32'h33);
        #1 check("t4_byp_busy_fwd", 32'(if_b.rd_busy[0]), 32'd0);
        check("t4_nob_busy_fwd", 32'(if_n.rd_busy[0]), 32'd1);
        tick();
        idle();
        #1 check("t4_busy_r3_clr", 32'(if_b.rd_busy[0]), 32'd0);
        check("t4_cnt1", 32'(if_n.pend_cnt), 32'd1);

        // Set and write of the same register in one cycle: the set wins, and the data still lands.
        set_rd(9, 3, 4);
        set_sb(9);
        set_wr(0, 9, 32'h99);
        tick();
        idle();
        #1 check("t5_busy_r9", 32'(if_b.rd_busy[0]), 32'd1);
        check("t5_data_r9", if_n.rd_data[31:0], 32'h99);
        check("t5_cnt", 32'(if_b.pend_cnt), 32'd2);

        repeat (10000) begin
            for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, NREGS - 1));
            wr_en       = NWR'($urandom);
            wr_addr     = (NWR*AW)'($urandom);
            wr_data     = {$urandom, $urandom};
            sb_set_en   = ($urandom_range(0, 2) == 0);
            sb_set_addr = AW'($urandom);
            if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wr_addr[AW-1:0];
            if ($urandom_range(0, 7) == 0) sb_set_addr = wr_addr[AW-1:0];
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
